// File: rtl/cpu_datapath.sv
// ----------------------------------------------------------------------------
// cpu_datapath
//
// Execution half of a microcoded 8-bit CPU. Each cycle it takes a 15-bit
// control word from the Controller and performs it. It holds the PC, MAR, IR,
// A, B, OUT and flag registers, the ALU, a 2**ADDRW-word program RAM and the
// shared bus. The IR opcode nibble goes back to the Controller. A separate
// program-load port fills RAM before a run.
//
// The Controller changes ctrlwrd on the falling edge. All state here updates
// on the rising edge, so the bus value has half a cycle to settle before use.
//
// Ports
//   clk          system clock, rising-edge state updates
//   resetn       asynchronous active-low reset (RAM is not cleared)
//   ctrlwrd      {HLT,MI,RI,RO,IO,II,AI,AO,SO,SU,BI,OI,CE,CO,J}, bit0 = J
//   load         program-load mode; inhibits every ctrlwrd action
//   progwe       RAM write strobe, honoured only while load = 1
//   progaddr     RAM load address
//   progdata     RAM load data
//   instruction  IR[DATAW-1 -: 4], opcode to the Controller
//   bus          current bus value
//   outreg       output (display) register
//   carry, zero  ALU flags, updated only on SO cycles
//   halted       sticky halt, cleared only by reset
//   buserr       more than one bus driver asserted this cycle
// ----------------------------------------------------------------------------
module cpu_datapath #(
    parameter int DATAW = 8,
    parameter int ADDRW = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [14:0]      ctrlwrd,
    input  logic             load,
    input  logic             progwe,
    input  logic [ADDRW-1:0] progaddr,
    input  logic [DATAW-1:0] progdata,
    output logic [3:0]       instruction,
    output logic [DATAW-1:0] bus,
    output logic [DATAW-1:0] outreg,
    output logic             carry,
    output logic             zero,
    output logic             halted,
    output logic             buserr
);

    // The field order matches the bit order of ctrlwrd: MSB first (HLT = bit14).
    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic so;
        logic su;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
    } ctrl_t;

    ctrl_t cw;
    assign cw = ctrl_t'(ctrlwrd);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDRW-1:0] pc_q,     pc_d;
    logic [ADDRW-1:0] mar_q,    mar_d;
    logic [DATAW-1:0] ir_q,     ir_d;
    logic [DATAW-1:0] a_q,      a_d;
    logic [DATAW-1:0] b_q,      b_d;
    logic [DATAW-1:0] out_q,    out_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;
    logic             halted_q, halted_d;

    logic [DATAW-1:0] mem_q [2**ADDRW];

    // ------------------------------------------------------------------------
    // ALU. SU selects A + ~B + 1. The carry-out then reads as "no borrow".
    // ------------------------------------------------------------------------
    logic [DATAW-1:0] alu_b;
    logic [DATAW-1:0] alu_res;
    logic             alu_c;

    assign alu_b = cw.su ? ~b_q : b_q;
    assign {alu_c, alu_res} = {1'b0, a_q} + {1'b0, alu_b} + (DATAW+1)'(cw.su);

    // ------------------------------------------------------------------------
    // Bus. The priority chain picks the winner. x & (x-1) is non-zero exactly
    // when two or more driver bits are set.
    // ------------------------------------------------------------------------
    logic [4:0] drivers;
    assign drivers = {cw.co, cw.ro, cw.io, cw.ao, cw.so};
    assign buserr  = |(drivers & (drivers - 5'd1));

    always_comb begin
        bus = '0;
        if (cw.co)      bus = DATAW'(pc_q);
        else if (cw.ro) bus = mem_q[mar_q];
        else if (cw.io) bus = DATAW'(ir_q[ADDRW-1:0]);
        else if (cw.ao) bus = a_q;
        else if (cw.so) bus = alu_res;
    end

    // Control-word actions take effect only in run mode and before a halt.
    logic exec_en;
    assign exec_en = ~load & ~halted_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every target is given its hold value first, so a path that
        // assigns nothing cannot leave a latch behind.
        pc_d     = pc_q;
        mar_d    = mar_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        halted_d = halted_q;

        if (exec_en) begin
            if (cw.mi) mar_d = bus[ADDRW-1:0];
            if (cw.ii) ir_d  = bus;
            if (cw.ai) a_d   = bus;
            if (cw.bi) b_d   = bus;
            if (cw.oi) out_d = bus;
            // A jump beats a count on the same edge.
            if (cw.j)       pc_d = bus[ADDRW-1:0];
            else if (cw.ce) pc_d = pc_q + ADDRW'(1);
            if (cw.so) begin
                carry_d = alu_c;
                zero_d  = (alu_res == '0);
            end
            if (cw.hlt) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge bus together, whatever the statement order.
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
        end
    end

    // ------------------------------------------------------------------------
    // Program RAM. The load port owns the write port while load = 1. In run
    // mode RI writes the bus at the pre-edge MAR.
    // ------------------------------------------------------------------------
    logic             ram_we;
    logic [ADDRW-1:0] ram_waddr;
    logic [DATAW-1:0] ram_wdata;

    assign ram_we    = load ? progwe   : (exec_en & cw.ri);
    assign ram_waddr = load ? progaddr : mar_q;
    assign ram_wdata = load ? progdata : bus;

    // NOTE: the RAM has no reset branch. Its contents must survive resetn,
    // and leaving it out keeps it mappable to a plain memory array.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instruction = ir_q[DATAW-1 -: 4];
    assign outreg      = out_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// ----------------------------------------------------------------------------
// tb_cpu_datapath
//
// Self-checking bench for cpu_datapath. It plays the Controller: it changes
// ctrlwrd on the falling edge and samples outputs 1 ns later, well away from
// the rising edge. Each scenario task pushes its expected values onto a
// scoreboard queue as it drives the stimulus. It queues the DUT values as
// they are sampled. At the end of the task it pops both queues and compares
// them pairwise.
// ----------------------------------------------------------------------------
module tb_cpu_datapath;

    localparam logic [14:0] C_J   = 15'h0001;
    localparam logic [14:0] C_CO  = 15'h0002;
    localparam logic [14:0] C_CE  = 15'h0004;
    localparam logic [14:0] C_OI  = 15'h0008;
    localparam logic [14:0] C_BI  = 15'h0010;
    localparam logic [14:0] C_SU  = 15'h0020;
    localparam logic [14:0] C_SO  = 15'h0040;
    localparam logic [14:0] C_AO  = 15'h0080;
    localparam logic [14:0] C_AI  = 15'h0100;
    localparam logic [14:0] C_II  = 15'h0200;
    localparam logic [14:0] C_IO  = 15'h0400;
    localparam logic [14:0] C_RO  = 15'h0800;
    localparam logic [14:0] C_RI  = 15'h1000;
    localparam logic [14:0] C_MI  = 15'h2000;
    localparam logic [14:0] C_HLT = 15'h4000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [14:0] ctrlwrd;
    logic        load;
    logic        progwe;
    logic [3:0]  progaddr;
    logic [7:0]  progdata;
    logic [3:0]  instruction;
    logic [7:0]  bus;
    logic [7:0]  outreg;
    logic        carry;
    logic        zero;
    logic        halted;
    logic        buserr;

    cpu_datapath #(.DATAW(8), .ADDRW(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ctrlwrd     (ctrlwrd),
        .load        (load),
        .progwe      (progwe),
        .progaddr    (progaddr),
        .progdata    (progdata),
        .instruction (instruction),
        .bus         (bus),
        .outreg      (outreg),
        .carry       (carry),
        .zero        (zero),
        .halted      (halted),
        .buserr      (buserr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] val;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] obs_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Scoreboard push helpers (no comparison here).
    task automatic expect_val(input string n, input logic [7:0] v);
        exp_q.push_back('{name: n, val: v});
    endtask

    task automatic observe(input logic [7:0] v);
        obs_q.push_back(v);
    endtask

    // ---------------- stimulus helpers ----------------
    // Present a word and let it execute on the next rising edge.
    task automatic cycle(input logic [14:0] cw);
        @(negedge clk);
        ctrlwrd = cw;
        @(posedge clk);
        #1;
    endtask

    // Present a word and return 1 ns later, before it reaches an edge.
    task automatic drive(input logic [14:0] cw);
        @(negedge clk);
        ctrlwrd = cw;
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ctrlwrd  = '0;
        load     = 1'b1;
        progwe   = 1'b1;
        progaddr = a;
        progdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic prog_done();
        @(negedge clk);
        progwe = 1'b0;
        load   = 1'b0;
    endtask

    task automatic fetch();
        cycle(C_CO | C_MI);
        cycle(C_RO | C_II | C_CE);
    endtask

    task automatic exec_lda();
        cycle(C_IO | C_MI);
        cycle(C_RO | C_AI);
    endtask

    task automatic exec_alu(input logic sub);
        cycle(C_IO | C_MI);
        cycle(C_RO | C_BI);
        cycle(C_SO | C_AI | (sub ? C_SU : 15'h0000));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        expect_val("rst_halted", 8'h00);      observe(8'(halted));
        expect_val("rst_outreg", 8'h00);      observe(outreg);
        expect_val("rst_carry", 8'h00);       observe(8'(carry));
        expect_val("rst_zero", 8'h00);        observe(8'(zero));
        expect_val("rst_instruction", 8'h00); observe(8'(instruction));
        expect_val("rst_bus_idle", 8'h00);    observe(bus);
        expect_val("rst_buserr", 8'h00);      observe(8'(buserr));
        @(negedge clk);
        resetn = 1'b1;
        drive(C_CO); expect_val("rst_pc", 8'h00); observe(bus);
        drive(C_AO); expect_val("rst_a", 8'h00);  observe(bus);
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL reset/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_program();
        prog(4'd0, 8'h1E); prog(4'd1, 8'h2F); prog(4'd2, 8'h50);
        prog(4'd3, 8'hF0); prog(4'd14, 8'h05); prog(4'd15, 8'h03);
        prog_done();
        fetch(); expect_val("op_lda", 8'h01); observe(8'(instruction));
        exec_lda();
        fetch(); expect_val("op_add", 8'h02); observe(8'(instruction));
        exec_alu(1'b0);
        fetch(); expect_val("op_out", 8'h05); observe(8'(instruction));
        cycle(C_AO | C_OI);
        fetch(); expect_val("op_hlt", 8'h0F); observe(8'(instruction));
        cycle(C_HLT);
        expect_val("outreg", 8'h08); observe(outreg);
        expect_val("carry", 8'h00);  observe(8'(carry));
        expect_val("zero", 8'h00);   observe(8'(zero));
        expect_val("halted", 8'h01); observe(8'(halted));
        drive(C_CO); expect_val("pc", 8'h04); observe(bus);
        drive(C_AO); expect_val("a", 8'h08);  observe(bus);
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL program/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    // Continues from the halted program: PC=4, A=8, B=3, MAR=3, IR=0xF0.
    task automatic test_halt();
        cycle(C_CO | C_AI | C_BI | C_RI | C_CE | C_MI | C_OI | C_II | C_SO | C_SU);
        drive(C_CO); expect_val("pc_held", 8'h04);  observe(bus);
        drive(C_AO); expect_val("a_held", 8'h08);   observe(bus);
        drive(C_RO); expect_val("ram_held", 8'hF0); observe(bus);
        expect_val("outreg_held", 8'h08); observe(outreg);
        expect_val("ir_held", 8'h0F);     observe(8'(instruction));
        expect_val("carry_held", 8'h00);  observe(8'(carry));
        expect_val("halted", 8'h01);      observe(8'(halted));
        drive(C_CO | C_AO);
        expect_val("co_ao_bus", 8'h04);    observe(bus);
        expect_val("co_ao_buserr", 8'h01); observe(8'(buserr));
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL halt/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(C_AO);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        expect_val("halted", 8'h00);      observe(8'(halted));
        expect_val("outreg", 8'h00);      observe(outreg);
        expect_val("instruction", 8'h00); observe(8'(instruction));
        expect_val("a_bus", 8'h00);       observe(bus);
        #1 resetn = 1'b1;
        drive(C_CO); expect_val("pc", 8'h00);       observe(bus);
        drive(C_RO); expect_val("ram0_kept", 8'h1E); observe(bus);
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL async_reset/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_alu();
        prog(4'd0, 8'h1A); prog(4'd1, 8'h3A); prog(4'd2, 8'h1C); prog(4'd3, 8'h3D);
        prog(4'd4, 8'h1E); prog(4'd5, 8'h2F); prog(4'd6, 8'h1C);
        prog(4'd10, 8'h03); prog(4'd12, 8'h02); prog(4'd13, 8'h05);
        prog(4'd14, 8'hFF); prog(4'd15, 8'h01);
        prog_done();
        fetch(); exec_lda(); fetch(); exec_alu(1'b1);          // 03 - 03
        drive(C_AO); expect_val("sub_eq_a", 8'h00); observe(bus);
        expect_val("sub_eq_c", 8'h01); observe(8'(carry));
        expect_val("sub_eq_z", 8'h01); observe(8'(zero));
        fetch(); exec_lda(); fetch(); exec_alu(1'b1);          // 02 - 05
        drive(C_AO); expect_val("sub_bor_a", 8'hFD); observe(bus);
        expect_val("sub_bor_c", 8'h00); observe(8'(carry));
        expect_val("sub_bor_z", 8'h00); observe(8'(zero));
        fetch(); exec_lda(); fetch(); exec_alu(1'b0);          // FF + 01
        drive(C_AO); expect_val("add_wrap_a", 8'h00); observe(bus);
        expect_val("add_wrap_c", 8'h01); observe(8'(carry));
        expect_val("add_wrap_z", 8'h01); observe(8'(zero));
        fetch(); exec_lda();                                   // no SO
        drive(C_AO); expect_val("lda_a", 8'h02); observe(bus);
        expect_val("flags_kept_c", 8'h01); observe(8'(carry));
        expect_val("flags_kept_z", 8'h01); observe(8'(zero));
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL alu/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    // State on entry: PC=7, A=02, B=01, MAR=0xC, IR=0x1C, C=1, Z=1, outreg=0.
    task automatic test_load_inhibit();
        @(negedge clk);
        load    = 1'b1;
        progwe  = 1'b0;
        ctrlwrd = C_AO | C_OI | C_CE | C_HLT | C_MI | C_II | C_SO;
        #1;
        expect_val("bus_live", 8'h02); observe(bus);
        @(posedge clk);
        #1;
        @(negedge clk);
        load    = 1'b0;
        ctrlwrd = '0;
        #1;
        expect_val("halted", 8'h00);      observe(8'(halted));
        expect_val("outreg", 8'h00);      observe(outreg);
        expect_val("carry", 8'h01);       observe(8'(carry));
        expect_val("zero", 8'h01);        observe(8'(zero));
        expect_val("instruction", 8'h01); observe(8'(instruction));
        drive(C_CO); expect_val("pc", 8'h07);  observe(bus);
        drive(C_RO); expect_val("mar", 8'h02); observe(bus);
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL load_inhibit/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    task automatic test_jump_wrap();
        prog(4'd7, 8'h6A);
        prog_done();
        fetch(); expect_val("op_6", 8'h06); observe(8'(instruction));
        cycle(C_IO | C_J | C_CE);
        drive(C_CO); expect_val("j_over_ce", 8'h0A); observe(bus);
        repeat (5) cycle(C_CE);
        drive(C_CO); expect_val("pc_f", 8'h0F); observe(bus);
        cycle(C_CE);
        drive(C_CO); expect_val("pc_wrap", 8'h00); observe(bus);
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL jump_wrap/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    // State on entry: PC=0, MAR=7 (RAM[7]=0x6A), IR=0x6A, A=02, B=01.
    task automatic test_bus_contention();
        cycle(C_CE);
        drive(C_CO | C_AO);
        expect_val("co_ao_bus", 8'h01); observe(bus);
        expect_val("co_ao_err", 8'h01); observe(8'(buserr));
        drive(C_RO | C_IO | C_SO);
        expect_val("ro_io_so_bus", 8'h6A); observe(bus);
        expect_val("ro_io_so_err", 8'h01); observe(8'(buserr));
        drive(C_IO | C_AO);
        expect_val("io_ao_bus", 8'h0A); observe(bus);
        expect_val("io_ao_err", 8'h01); observe(8'(buserr));
        drive(C_SO);
        expect_val("so_bus", 8'h03); observe(bus);
        expect_val("so_err", 8'h00); observe(8'(buserr));
        drive('0);
        expect_val("idle_bus", 8'h00); observe(bus);
        expect_val("idle_err", 8'h00); observe(8'(buserr));
        while (exp_q.size() > 0) begin
            item_t e; logic [7:0] o;
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL bus/%s: got 0x%02h, expected 0x%02h", e.name, o, e.val);
            end
        end
    endtask

    initial begin
        resetn   = 1'b0;
        ctrlwrd  = '0;
        load     = 1'b0;
        progwe   = 1'b0;
        progaddr = '0;
        progdata = '0;
        test_reset();
        test_program();
        test_halt();
        test_async_reset();
        test_alu();
        test_load_inhibit();
        test_jump_wrap();
        test_bus_contention();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
